// File: rtl/bram_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bram_flush_ctrl
// Purpose  : BRAM write-port sequencer: registered user-write pass-through,
//            or a full sweep of every word with FLUSH_VALUE on request.
// Revision : 1.0
// ============================================================================
module bram_flush_ctrl #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    DATA_WIDTH  = 36,
  parameter int                    DEPTH       = 1024,
  parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_en,
  input  logic                  flush_req,
  input  logic                  usr_we,
  input  logic [ADDR_WIDTH-1:0] usr_addr,
  input  logic [DATA_WIDTH-1:0] usr_wdata,
  output logic                  usr_ready,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One extra counter bit lets DEPTH == 2**ADDR_WIDTH terminate without wrap.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    start;

  assign start     = flush_en & flush_req;
  assign usr_ready = (state_q == IDLE) & ~start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FLUSH;
          cnt_d   = {{ADDR_WIDTH{1'b0}}, 1'b1};
          we_d    = 1'b1;
          addr_d  = '0;
          wdata_d = FLUSH_VALUE;
          busy_d  = 1'b1;
        end else if (usr_we) begin
          we_d    = 1'b1;
          addr_d  = usr_addr;
          wdata_d = usr_wdata;
        end
      end
      FLUSH: begin
        // cnt is one ahead of the address currently on the BRAM port.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = FLUSH_VALUE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_flush_ctrl
// Purpose  : Directed self-checking bench for bram_flush_ctrl (DEPTH=8).
// Revision : 1.0
// ============================================================================
module tb_bram_flush_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 36;
  localparam int DEPTH = 8;

  logic          clk;
  logic          reset;
  logic          flush_en;
  logic          flush_req;
  logic          usr_we;
  logic [AW-1:0] usr_addr;
  logic [DW-1:0] usr_wdata;
  logic          usr_ready;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  bram_flush_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .FLUSH_VALUE(36'h0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush_en  (flush_en),
    .flush_req (flush_req),
    .usr_we    (usr_we),
    .usr_addr  (usr_addr),
    .usr_wdata (usr_wdata),
    .usr_ready (usr_ready),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_wdata(bram_wdata),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush_en  = 1'b1;
    flush_req = 1'b0;
    usr_we    = 1'b0;
    usr_addr  = '0;
    usr_wdata = '0;

    // Reset state
    step();
    step();
    chk("rst_we",    64'(bram_we),    64'h0);
    chk("rst_addr",  64'(bram_addr),  64'h0);
    chk("rst_wdata", 64'(bram_wdata), 64'h0);
    chk("rst_busy",  64'(busy),       64'h0);
    chk("rst_done",  64'(done),       64'h0);
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(usr_ready),  64'h1);

    // User write pass-through with one cycle of latency
    usr_we    = 1'b1;
    usr_addr  = 10'h005;
    usr_wdata = 36'hA5A5A5A5A;
    step();
    usr_we = 1'b0;
    chk("uw_we",    64'(bram_we),    64'h1);
    chk("uw_addr",  64'(bram_addr),  64'h5);
    chk("uw_wdata", 64'(bram_wdata), 64'hA5A5A5A5A);
    step();
    chk("uw_we_off",    64'(bram_we),    64'h0);
    chk("uw_addr_hold", 64'(bram_addr),  64'h5);
    chk("uw_data_hold", 64'(bram_wdata), 64'hA5A5A5A5A);

    // Single-cycle flush request: sweep 0..7, done at t+9, ready at t+10
    flush_req = 1'b1;
    #1;
    chk("fl_ready_t", 64'(usr_ready), 64'h0);
    step();
    flush_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fl_we",    64'(bram_we),    64'h1);
      chk("fl_addr",  64'(bram_addr),  64'(i));
      chk("fl_wdata", 64'(bram_wdata), 64'h0);
      chk("fl_busy",  64'(busy),       64'h1);
      chk("fl_done",  64'(done),       64'h0);
      chk("fl_ready", 64'(usr_ready),  64'h0);
      step();
    end
    chk("fl_done_pulse", 64'(done),    64'h1);
    chk("fl_done_busy",  64'(busy),    64'h1);
    chk("fl_done_we",    64'(bram_we), 64'h0);
    step();
    chk("fl_end_done",  64'(done),      64'h0);
    chk("fl_end_busy",  64'(busy),      64'h0);
    chk("fl_end_ready", 64'(usr_ready), 64'h1);
    chk("fl_end_addr",  64'(bram_addr), 64'h7);

    // Flush start beats a simultaneous user write; writes during flush ignored
    flush_req = 1'b1;
    usr_we    = 1'b1;
    usr_addr  = 10'h123;
    usr_wdata = 36'h123456789;
    #1;
    chk("col_ready", 64'(usr_ready), 64'h0);
    step();
    flush_req = 1'b0;
    usr_addr  = 10'h155;
    for (int i = 0; i < DEPTH; i++) begin
      chk("col_we",    64'(bram_we),    64'h1);
      chk("col_addr",  64'(bram_addr),  64'(i));
      chk("col_wdata", 64'(bram_wdata), 64'h0);
      chk("col_ready_busy", 64'(usr_ready), 64'h0);
      step();
    end
    chk("col_done", 64'(done),    64'h1);
    chk("col_we_d", 64'(bram_we), 64'h0);
    usr_we = 1'b0;
    step();
    chk("col_idle_we",   64'(bram_we),   64'h0);
    chk("col_idle_addr", 64'(bram_addr), 64'h7);

    // flush_en low: held flush_req ignored, user writes still pass
    flush_en  = 1'b0;
    flush_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        usr_we    = 1'b1;
        usr_addr  = 10'h2AA;
        usr_wdata = 36'hFEDCBA987;
      end
      #1;
      chk("dis_ready", 64'(usr_ready), 64'h1);
      step();
      chk("dis_busy", 64'(busy), 64'h0);
      chk("dis_done", 64'(done), 64'h0);
      if (i == 5) begin
        usr_we = 1'b0;
        chk("dis_uw_we",    64'(bram_we),    64'h1);
        chk("dis_uw_addr",  64'(bram_addr),  64'h2AA);
        chk("dis_uw_wdata", 64'(bram_wdata), 64'hFEDCBA987);
      end else begin
        chk("dis_we", 64'(bram_we), 64'h0);
      end
    end
    flush_req = 1'b0;
    flush_en  = 1'b1;
    step();

    // Reset at t+4 of a flush aborts with no done pulse
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    step();
    step();
    chk("ab_addr_t4", 64'(bram_addr), 64'h3);
    chk("ab_busy_t4", 64'(busy),      64'h1);
    reset = 1'b1;
    step();
    chk("ab_we",    64'(bram_we),   64'h0);
    chk("ab_busy",  64'(busy),      64'h0);
    chk("ab_done",  64'(done),      64'h0);
    chk("ab_addr",  64'(bram_addr), 64'h0);
    reset = 1'b0;
    #1;
    chk("ab_ready", 64'(usr_ready), 64'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ab_quiet_done", 64'(done),    64'h0);
      chk("ab_quiet_we",   64'(bram_we), 64'h0);
    end

    // Restarted flush begins at address 0 and completes normally
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("rs_we",   64'(bram_we),   64'h1);
      chk("rs_addr", 64'(bram_addr), 64'(i));
      step();
    end
    chk("rs_done", 64'(done), 64'h1);
    step();
    chk("rs_ready", 64'(usr_ready), 64'h1);
    chk("rs_busy",  64'(busy),      64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_flush_ctrl.md
Name: bram_flush_ctrl

Overview:
- Sequencer that sits directly downstream of the flush-option constant-logic1 tile in the BRAM tile's flush_opt mode.
- Consumes the tied-high flush_en and, on request, sweeps every BRAM word with a fixed flush value.
- In idle it muxes the user write port through to the BRAM write port with one registered stage.
- It is the only driver of the BRAM write port in flush_opt mode.

Parameters:
- ADDR_WIDTH, 10, BRAM address width.
- DATA_WIDTH, 36, BRAM data width.
- DEPTH, 1024, number of words flushed, addresses 0..DEPTH-1; legal range 2..2**ADDR_WIDTH.
- FLUSH_VALUE, {DATA_WIDTH{1'b0}}, word written to every address during a flush.

Ports:
- clk  input  1  fabric clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush_en  input  1  flush-option enable, driven by the logic1 primitive output (constant 1 in flush_opt mode).
- flush_req  input  1  level request to start a flush; sampled only in IDLE.
- usr_we  input  1  user write strobe.
- usr_addr  input  ADDR_WIDTH  user write address.
- usr_wdata  input  DATA_WIDTH  user write data.
- usr_ready  output  1  combinational; high when a user write is accepted this cycle.
- bram_we  output  1  registered BRAM write enable.
- bram_addr  output  ADDR_WIDTH  registered BRAM write address.
- bram_wdata  output  DATA_WIDTH  registered BRAM write data.
- busy  output  1  registered; high while the state is not IDLE.
- done  output  1  registered; one-cycle pulse when a flush completes.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state=IDLE, cnt=0, bram_we=0, bram_addr=0, bram_wdata=0, busy=0, done=0. usr_ready=1 from the first cycle after reset unless a flush start is presented.
- States: IDLE, FLUSH, DONE.
  - IDLE: if flush_en & flush_req, then next state FLUSH, cnt<=1, bram_we<=1, bram_addr<=0, bram_wdata<=FLUSH_VALUE, busy<=1.
  - IDLE, else if usr_we & usr_ready: next cycle bram_we=1, bram_addr=usr_addr, bram_wdata=usr_wdata (1-cycle latency).
  - IDLE, else: bram_we<=0; bram_addr and bram_wdata hold their last values.
  - FLUSH: each cycle bram_we<=1, bram_addr<=cnt, bram_wdata<=FLUSH_VALUE, cnt<=cnt+1. When the write of address DEPTH-1 is being presented, the next state is DONE.
  - DONE: bram_we<=0, done=1 for exactly this cycle, busy stays 1. Next state IDLE, busy<=0, cnt<=0.
- usr_ready = (state==IDLE) & ~(flush_en & flush_req).
  - A flush start wins over a simultaneous user write; that user write is not accepted and must be held by the requester.
- Timing from request accepted at cycle t:
  - bram_we high with addr 0..DEPTH-1 in cycles t+1..t+DEPTH.
  - done high at t+DEPTH+1.
  - busy high t+1..t+DEPTH+1.
  - usr_ready high again at t+DEPTH+2 if no new request.
- flush_en=0: flush_req is ignored entirely; the block behaves as a pure user-write register stage.
- flush_en and flush_req are don't-care outside IDLE. Deasserting either mid-flush does not abort; a held flush_req does not re-trigger until IDLE is re-entered. A level-held request starts a new flush on the first IDLE cycle.
- cnt width is ADDR_WIDTH+1 so DEPTH=2**ADDR_WIDTH terminates with no wrap. bram_addr never exceeds DEPTH-1 during a flush.
- usr_we while busy is ignored (usr_ready=0); no buffering.
- Reset mid-flush: the next cycle is the reset state. bram_we=0, no done pulse, remaining addresses are not written.

Test Plan:
- DEPTH=8, FLUSH_VALUE=36'h0; reset for 2 cycles -> all registered outputs 0, usr_ready=1, busy=0.
- IDLE, usr_we=1, usr_addr=10'h05, usr_wdata=36'hA5A5A5A5A -> next cycle bram_we=1, bram_addr=5, bram_wdata=36'hA5A5A5A5A; following cycle bram_we=0, addr and data held.
- flush_en=1, one-cycle flush_req at t -> bram_we=1, addr 0..7 consecutive at t+1..t+8, data 0; done=1 only at t+9; busy t+1..t+9; usr_ready=1 at t+10.
- flush_req and usr_we both high in the same IDLE cycle -> usr_ready=0, flush starts at addr 0, the user write never appears; usr_we during the flush produces no bram_we with a user address.
- flush_en=0, flush_req=1 held 20 cycles -> busy stays 0, done never pulses, user writes pass through normally.
- Reset asserted at t+4 of a flush -> at t+5 bram_we=0, busy=0, state IDLE, no done pulse; a new flush_req restarts at addr 0.
